// File: rtl/mem_bus_ctrl.sv
// ============================================================================
// Module      : mem_bus_ctrl
// Description : Bridges the CPU data bus to a single-port synchronous SRAM
//               with one-cycle read latency. Inserts WAIT_STATES idle cycles
//               before the SRAM access and rejects misaligned or
//               out-of-range accesses with a one-cycle fault response.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_ctrl #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic [31:0]           db_addr,
    input  logic [1:0]            db_accessType,
    input  logic [31:0]           db_dataOut,
    output logic [31:0]           db_dataIn,
    output logic                  db_ready,
    output logic                  bus_fault,
    output logic                  busy,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata
);

    // Access type encoding shared with the CPU data bus
    localparam logic [1:0] ACC_NONE = 2'd0;
    localparam logic [1:0] ACC_R    = 2'd1;
    localparam logic [1:0] ACC_W    = 2'd2;
    localparam logic [1:0] ACC_X    = 2'd3;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_MEM   = 3'd2,
        S_RESP  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            type_q, type_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;

    logic misaligned;
    logic out_of_range;

    // Address checks on the live bus; only consulted when capturing in IDLE
    always_comb begin
        misaligned   = (db_addr[1:0] != 2'b00);
        out_of_range = ((db_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    end

    // State and request registers; reset abandons any access in flight
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            type_q     <= ACC_NONE;
            wdata_q    <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            type_q     <= type_d;
            wdata_q    <= wdata_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state logic: capture in IDLE, count waits, then one MEM and one response cycle
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        type_d     = type_q;
        wdata_d    = wdata_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (db_accessType != ACC_NONE) begin
                    addr_d  = db_addr[ADDR_WIDTH+1:2];
                    type_d  = db_accessType;
                    wdata_d = db_dataOut;
                    if (misaligned || out_of_range) begin
                        state_d = S_FAULT;
                    end else if (WAIT_STATES == 0) begin
                        state_d = S_MEM;
                    end else begin
                        wait_cnt_d = WAIT_LOAD;
                        state_d    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (wait_cnt_q == 4'd1) begin
                    state_d = S_MEM;
                end
            end
            S_MEM:   state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: SRAM side depends only on state and latched registers
    always_comb begin
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = addr_q;
        sram_wdata = wdata_q;
        db_ready   = 1'b0;
        bus_fault  = 1'b0;
        db_dataIn  = 32'd0;
        busy       = (state_q != S_IDLE);
        case (state_q)
            S_MEM: begin
                sram_en = 1'b1;
                sram_we = (type_q == ACC_W);
            end
            S_RESP: begin
                db_ready  = 1'b1;
                db_dataIn = ((type_q == ACC_R) || (type_q == ACC_X)) ? sram_rdata : 32'd0;
            end
            S_FAULT: begin
                db_ready  = 1'b1;
                bus_fault = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_ctrl.sv
// ============================================================================
// Module      : tb_mem_bus_ctrl
// Description : Self-checking bench for mem_bus_ctrl. A behavioural SRAM
//               serves the DUT; a word-array reference memory plus simple
//               latency arithmetic provide every expected value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_ctrl;

    localparam int AW = 12;
    localparam int WS = 2;
    localparam int NW = 64;

    localparam logic [1:0] ACC_NONE = 2'd0;
    localparam logic [1:0] ACC_R    = 2'd1;
    localparam logic [1:0] ACC_W    = 2'd2;
    localparam logic [1:0] ACC_X    = 2'd3;

    logic          clk = 1'b0;
    logic          res;
    logic [31:0]   db_addr;
    logic [1:0]    db_accessType;
    logic [31:0]   db_dataOut;
    logic [31:0]   db_dataIn;
    logic          db_ready;
    logic          bus_fault;
    logic          busy;
    logic          sram_en;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;

    // preload port into the SRAM model
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [31:0]   pl_data = '0;

    logic [31:0] sram    [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:NW-1];

    int n_cmp  = 0;
    int n_fail = 0;

    // results of the most recent access
    int          lat, en_cnt, we_cnt, en_cyc, busy_cnt;
    logic        flt;
    logic [31:0] dat, en_wdata;
    logic [AW-1:0] en_addr;
    logic [2:0]  c0;

    mem_bus_ctrl #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
        .clk           (clk),
        .res           (res),
        .db_addr       (db_addr),
        .db_accessType (db_accessType),
        .db_dataOut    (db_dataOut),
        .db_dataIn     (db_dataIn),
        .db_ready      (db_ready),
        .bus_fault     (bus_fault),
        .busy          (busy),
        .sram_en       (sram_en),
        .sram_we       (sram_we),
        .sram_addr     (sram_addr),
        .sram_wdata    (sram_wdata),
        .sram_rdata    (sram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port SRAM, one-cycle read latency
    always @(posedge clk) begin
        if (pl_en) begin
            sram[pl_addr] <= pl_data;
        end else if (sram_en) begin
            if (sram_we) sram[sram_addr] <= sram_wdata;
            else         sram_rdata <= sram[sram_addr];
        end
    end

    // Present one request and observe it until db_ready (bounded).
    // b2b=1: called in a ready cycle, latency counts from that cycle.
    task automatic run_access(input bit b2b, input logic [1:0] t, input logic [31:0] a,
                              input logic [31:0] d,
                              output int o_lat, output logic o_flt, output logic [31:0] o_dat,
                              output int o_en, output int o_we, output int o_encyc,
                              output logic [AW-1:0] o_enaddr, output logic [31:0] o_enwd,
                              output int o_busy, output logic [2:0] o_c0);
        o_lat = 0; o_flt = 1'b0; o_dat = '0; o_en = 0; o_we = 0; o_encyc = 0;
        o_enaddr = '0; o_enwd = '0; o_busy = 0; o_c0 = '0;
        if (!b2b) begin
            @(posedge clk); #1;
        end
        db_accessType = t; db_addr = a; db_dataOut = d;
        #1;
        o_c0 = {db_ready, sram_en, busy};
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (busy) o_busy++;
            if (sram_en) begin
                o_en++; o_encyc = c; o_enaddr = sram_addr; o_enwd = sram_wdata;
                if (sram_we) o_we++;
            end
            if (db_ready) begin
                o_lat = c; o_flt = bus_fault; o_dat = db_dataIn;
                break;
            end
        end
        db_accessType = ACC_NONE;
        db_addr       = $urandom;
        db_dataOut    = $urandom;
    endtask

    task automatic test_reset();
        res = 1'b0;
        db_accessType = ACC_NONE; db_addr = '0; db_dataOut = '0;
        for (int i = 0; i < NW; i++) begin
            logic [31:0] v;
            v = (i == 5) ? 32'hDEADBEEF : $urandom;
            ref_mem[i] = v;
            pl_en = 1'b1; pl_addr = AW'(i); pl_data = v;
            @(posedge clk); #1;
        end
        pl_en = 1'b0;
        n_cmp++;
        if ({db_ready, bus_fault, busy, sram_en, sram_we} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 00000",
                               {db_ready, bus_fault, busy, sram_en, sram_we});
        end
        n_cmp++;
        if ({sram_addr, sram_wdata, db_dataIn} !== '0) begin
            n_fail++; $display("FAIL reset_data: addr %h wdata %h dataIn %h expected all 0",
                               sram_addr, sram_wdata, db_dataIn);
        end
        res = 1'b1;
    endtask

    task automatic test_read_ws();
        run_access(1'b0, ACC_X, 32'h14, 32'h0, lat, flt, dat, en_cnt, we_cnt, en_cyc,
                   en_addr, en_wdata, busy_cnt, c0);
        n_cmp++;
        if (c0 !== 3'b000) begin n_fail++; $display("FAIL read_ws cycle0: got %b expected 000", c0); end
        n_cmp++;
        if (lat !== 2 + WS) begin n_fail++; $display("FAIL read_ws latency: got %0d expected %0d", lat, 2 + WS); end
        n_cmp++;
        if (en_cnt !== 1 || en_cyc !== 1 + WS || en_addr !== AW'(5) || we_cnt !== 0) begin
            n_fail++; $display("FAIL read_ws sram: en %0d at cyc %0d addr %h we %0d expected 1 at %0d addr 005 we 0",
                               en_cnt, en_cyc, en_addr, we_cnt, 1 + WS);
        end
        n_cmp++;
        if (dat !== 32'hDEADBEEF || flt !== 1'b0) begin
            n_fail++; $display("FAIL read_ws data: got %h fault %b expected deadbeef fault 0", dat, flt);
        end
        n_cmp++;
        if (busy_cnt !== 2 + WS) begin n_fail++; $display("FAIL read_ws busy: got %0d expected %0d", busy_cnt, 2 + WS); end
    endtask

    task automatic test_write_read();
        run_access(1'b0, ACC_W, 32'h40, 32'h12345678, lat, flt, dat, en_cnt, we_cnt, en_cyc,
                   en_addr, en_wdata, busy_cnt, c0);
        ref_mem[16] = 32'h12345678;
        n_cmp++;
        if (we_cnt !== 1 || en_addr !== AW'(16) || en_wdata !== 32'h12345678) begin
            n_fail++; $display("FAIL write sram: we %0d addr %h wdata %h expected 1 010 12345678",
                               we_cnt, en_addr, en_wdata);
        end
        n_cmp++;
        if (lat !== 2 + WS || dat !== 32'd0 || flt !== 1'b0) begin
            n_fail++; $display("FAIL write resp: lat %0d data %h fault %b expected %0d 0 0", lat, dat, flt, 2 + WS);
        end
        run_access(1'b0, ACC_R, 32'h40, 32'h0, lat, flt, dat, en_cnt, we_cnt, en_cyc,
                   en_addr, en_wdata, busy_cnt, c0);
        n_cmp++;
        if (dat !== ref_mem[16] || lat !== 2 + WS) begin
            n_fail++; $display("FAIL read_after_write: data %h lat %0d expected %h %0d", dat, lat, ref_mem[16], 2 + WS);
        end
    endtask

    task automatic test_misaligned();
        run_access(1'b0, ACC_R, 32'h102, 32'h0, lat, flt, dat, en_cnt, we_cnt, en_cyc,
                   en_addr, en_wdata, busy_cnt, c0);
        n_cmp++;
        if (lat !== 1 || flt !== 1'b1 || dat !== 32'd0 || en_cnt !== 0) begin
            n_fail++; $display("FAIL misaligned: lat %0d fault %b data %h en %0d expected 1 1 0 0",
                               lat, flt, dat, en_cnt);
        end
    endtask

    task automatic test_out_of_range();
        run_access(1'b0, ACC_W, 32'h4000, 32'hCAFEF00D, lat, flt, dat, en_cnt, we_cnt, en_cyc,
                   en_addr, en_wdata, busy_cnt, c0);
        n_cmp++;
        if (lat !== 1 || flt !== 1'b1 || en_cnt !== 0 || we_cnt !== 0) begin
            n_fail++; $display("FAIL out_of_range: lat %0d fault %b en %0d we %0d expected 1 1 0 0",
                               lat, flt, en_cnt, we_cnt);
        end
        run_access(1'b0, ACC_R, 32'h0, 32'h0, lat, flt, dat, en_cnt, we_cnt, en_cyc,
                   en_addr, en_wdata, busy_cnt, c0);
        n_cmp++;
        if (dat !== ref_mem[0] || flt !== 1'b0) begin
            n_fail++; $display("FAIL out_of_range word0: got %h fault %b expected %h 0", dat, flt, ref_mem[0]);
        end
    endtask

    task automatic test_back_to_back();
        run_access(1'b0, ACC_X, 32'h0, 32'h0, lat, flt, dat, en_cnt, we_cnt, en_cyc,
                   en_addr, en_wdata, busy_cnt, c0);
        n_cmp++;
        if (dat !== ref_mem[0] || lat !== 2 + WS) begin
            n_fail++; $display("FAIL b2b first: data %h lat %0d expected %h %0d", dat, lat, ref_mem[0], 2 + WS);
        end
        run_access(1'b1, ACC_R, 32'h8, 32'h0, lat, flt, dat, en_cnt, we_cnt, en_cyc,
                   en_addr, en_wdata, busy_cnt, c0);
        n_cmp++;
        if (lat !== 3 + WS) begin n_fail++; $display("FAIL b2b spacing: got %0d expected %0d", lat, 3 + WS); end
        n_cmp++;
        if (dat !== ref_mem[2] || en_addr !== AW'(2)) begin
            n_fail++; $display("FAIL b2b second: data %h addr %h expected %h 002", dat, en_addr, ref_mem[2]);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 1'b0;
        @(posedge clk); #1;
        db_accessType = ACC_W; db_addr = 32'h80; db_dataOut = 32'hA5A55A5A;
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_mid busy_before: got %b expected 1", busy); end
        #2 res = 1'b0;
        #1;
        n_cmp++;
        if ({db_ready, bus_fault, busy, sram_en, sram_we, sram_addr, sram_wdata, db_dataIn} !== '0) begin
            n_fail++; $display("FAIL reset_mid async: ready %b fault %b busy %b en %b we %b addr %h wdata %h expected all 0",
                               db_ready, bus_fault, busy, sram_en, sram_we, sram_addr, sram_wdata);
        end
        db_accessType = ACC_NONE;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (sram_en || sram_we) seen = 1'b1;
        end
        res = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (sram_en || sram_we || busy || db_ready) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL reset_mid idle: activity %b expected 0", seen); end
        run_access(1'b0, ACC_R, 32'h80, 32'h0, lat, flt, dat, en_cnt, we_cnt, en_cyc,
                   en_addr, en_wdata, busy_cnt, c0);
        n_cmp++;
        if (dat !== ref_mem[32]) begin n_fail++; $display("FAIL reset_mid memory: got %h expected %h", dat, ref_mem[32]); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            bit          b2b, fault;
            int          sel, w, exp_lat;
            logic [1:0]  t;
            logic [31:0] a, d, exp_dat;
            b2b = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            w   = $urandom_range(0, NW - 1);
            case ($urandom_range(0, 2))
                0:       t = ACC_R;
                1:       t = ACC_W;
                default: t = ACC_X;
            endcase
            d = $urandom;
            if (sel <= 6)      a = w * 4;
            else if (sel == 7) a = w * 4 + $urandom_range(1, 3);
            else               a = w * 4 + (32'h1 << $urandom_range(AW + 2, 31));
            fault   = (a % 4 != 0) || (a >= (32'h1 << (AW + 2)));
            exp_lat = (fault ? 1 : 2 + WS) + (b2b ? 1 : 0);
            exp_dat = (fault || t == ACC_W) ? 32'd0 : ref_mem[a / 4];
            run_access(b2b, t, a, d, lat, flt, dat, en_cnt, we_cnt, en_cyc,
                       en_addr, en_wdata, busy_cnt, c0);
            if (!fault && t == ACC_W) ref_mem[a / 4] = d;
            n_cmp++;
            if (lat !== exp_lat || flt !== fault || dat !== exp_dat) begin
                n_fail++; $display("FAIL random[%0d] resp t=%0d a=%h: lat %0d fault %b data %h expected %0d %b %h",
                                   n, t, a, lat, flt, dat, exp_lat, fault, exp_dat);
            end
            n_cmp++;
            if (en_cnt !== (fault ? 0 : 1) || we_cnt !== ((!fault && t == ACC_W) ? 1 : 0) ||
                (!fault && en_addr !== AW'(a / 4))) begin
                n_fail++; $display("FAIL random[%0d] sram t=%0d a=%h: en %0d we %0d addr %h",
                                   n, t, a, en_cnt, we_cnt, en_addr);
            end
            n_cmp++;
            if (c0 !== (b2b ? 3'b101 : 3'b000)) begin
                n_fail++; $display("FAIL random[%0d] cycle0: got %b expected %b", n, c0, b2b ? 3'b101 : 3'b000);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_ws();
        test_write_read();
        test_misaligned();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Bridges the CPU core's data bus (`db_*`) to a single-port synchronous SRAM with a one-cycle read latency. It inserts a configurable number of wait states and rejects misaligned or out-of-range accesses with a fault. It sits directly downstream of the CPU core, driving `db_ready` and `db_dataIn` back to it, and serves instruction fetch (X), load (R) and store (W) accesses identically apart from write enable.

## Interface
- `ADDR_WIDTH`, default 12: SRAM word-address width; the SRAM holds 2^ADDR_WIDTH 32-bit words.
- `WAIT_STATES`, default 0: extra idle cycles between request capture and SRAM access, range 0..15.
- `clk`  in  1  clock; all state updates on rising edge.
- `res`  in  1  reset; asynchronous assert, active-low (0 = reset).
- `db_addr`  in  32  byte address from the CPU.
- `db_accessType`  in  `MEM_ACCESS_T`  NONE/R/W/X encoding from DataBus.vh.
- `db_dataOut`  in  32  store data from the CPU.
- `db_dataIn`  out  32  read data to the CPU; valid only while `db_ready`=1.
- `db_ready`  out  1  one-cycle completion pulse.
- `bus_fault`  out  1  high together with `db_ready` when the access was rejected.
- `busy`  out  1  high in every state except IDLE.
- `sram_en`  out  1  SRAM enable.
- `sram_we`  out  1  SRAM write enable.
- `sram_addr`  out  ADDR_WIDTH  SRAM word address.
- `sram_wdata`  out  32  SRAM write data.
- `sram_rdata`  in  32  SRAM read data; valid the cycle after `sram_en`=1 with `sram_we`=0.

## Operation
- States: IDLE, WAIT, MEM, RESP, FAULT.
- **Request protocol.** The CPU holds `db_addr`, `db_accessType` and `db_dataOut` stable until it sees `db_ready`. In the `db_ready` cycle the CPU already presents its next request.
- **IDLE.**
  - If `db_accessType` is NONE, stay in IDLE.
  - Otherwise latch addr, type and wdata into internal registers. The bus is ignored until the next IDLE.
  - If `addr[1:0]`≠0, or `addr[31:ADDR_WIDTH+2]`≠0, go to FAULT.
  - Else, if WAIT_STATES=0, go to MEM.
  - Else load the wait counter with WAIT_STATES and go to WAIT.
- **WAIT.** Decrement the counter each cycle. When the counter equals 1, go to MEM.
- **MEM.**
  - `sram_en`=1 and `sram_addr`=latched `addr[ADDR_WIDTH+1:2]`.
  - `sram_we`=1 and `sram_wdata`=latched wdata only for type W.
  - Next state: RESP.
- **RESP.**
  - `db_ready`=1.
  - `db_dataIn`=`sram_rdata` for R or X; 0 for W.
  - Next state: IDLE.
- **FAULT.**
  - `db_ready`=1, `bus_fault`=1, `db_dataIn`=0.
  - No SRAM activity; no write is performed.
  - Next state: IDLE.
- **Output defaults.** Outside the states listed above, `sram_en`, `sram_we`, `db_ready` and `bus_fault` are 0, and `db_dataIn` is 0. `sram_addr` and `sram_wdata` hold the latched values.
- **Request capture.** A request presented during RESP or FAULT is not captured in that cycle. It is captured in the following IDLE cycle, because the CPU is still holding it.
- **Reset.** Forces IDLE immediately, even mid-access. All outputs go to 0, and the latched registers and wait counter clear to 0. An access interrupted by reset never completes, and a write interrupted before MEM never reaches the SRAM.

## Timing
- Cycle 0 is the IDLE cycle that captures the request.
- Valid access: MEM in cycle 1+WAIT_STATES; `db_ready` in cycle 2+WAIT_STATES.
- Fault: `db_ready`+`bus_fault` in cycle 1, independent of WAIT_STATES.
- Back-to-back throughput: one access per 3+WAIT_STATES cycles (capture, waits, MEM, RESP).
- `db_ready` is never high for two consecutive cycles.
- `db_dataIn` and `db_ready` are combinational from state plus `sram_rdata`. SRAM control outputs are combinational from state plus registers only, with no path from bus inputs.

## Test plan
- **Read, WAIT_STATES=2.** Preload word 5=0xDEADBEEF; present X at addr 0x14 in cycle 0 → `sram_en` only in cycle 3 with `sram_addr`=5; `db_ready`=1 with `db_dataIn`=0xDEADBEEF in cycle 4 only; `bus_fault`=0.
- **Write then read.** W addr 0x40, data 0x12345678 → `sram_we`=1 with `sram_addr`=0x10 in MEM; `db_ready` next cycle with `db_dataIn`=0. A following R at 0x40 returns 0x12345678.
- **Misaligned address.** R at 0x102 → `db_ready`=`bus_fault`=1 in cycle 1; `sram_en` never asserted.
- **Out-of-range address.** W at 0x4000 with ADDR_WIDTH=12 → fault pulse in cycle 1; a subsequent read of word 0 shows memory unchanged.
- **Back-to-back.** X at 0x0, then CPU presents R at 0x8 in the ready cycle → second capture in the cycle after ready; second `db_ready` exactly 3+WAIT_STATES cycles after the first.
- **Reset mid-access.** Drive `res`=0 during WAIT of a W → all outputs 0 asynchronously; no `sram_we` pulse. After `res`=1 with `db_accessType`=NONE, stays IDLE with `busy`=0.
